// File: rtl/ex_mem_ctrl.sv
// Execute/memory stage controller: takes one instruction at a time, runs the
// memory request handshake or waits for mul/div, then holds the result for writeback.
module ex_mem_ctrl #(
   parameter int XLEN   = 32,
   parameter bit ALE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_re,
   input  logic              in_we,
   input  logic              in_mc,
   input  logic [2:0]        in_access_sz,
   input  logic [XLEN-1:0]   in_alu_out,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic [XLEN-1:0]   in_mc_out,
   input  logic              in_mc_valid,
   input  logic              in_rd_wen,
   output logic              mm_req,
   input  logic              mm_addr_ok,
   output logic              mm_we,
   output logic [XLEN-1:0]   mm_addr,
   output logic [XLEN-1:0]   mm_wdata,
   output logic [XLEN/8-1:0] mm_wstrb,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic              out_rd_wen,
   output logic              out_ale
);
   localparam int STRB_W = XLEN / 8;
   localparam int OFS_W  = $clog2(STRB_W);

   localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
   localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
   localparam logic [2:0] ACCESS_SZ_WORD = 3'd2;

   localparam logic [STRB_W-1:0] STRB_BYTE = STRB_W'(1);
   localparam logic [STRB_W-1:0] STRB_HALF = STRB_W'(3);
   localparam logic [STRB_W-1:0] STRB_WORD = STRB_W'(15);

   typedef enum logic [1:0] {IDLE, MC_WAIT, MEM_REQ, HOLD} state_t;

   state_t            state;
   logic              pend_flush;
   logic              is_mem;
   logic              ale;
   logic              accept;
   logic [OFS_W-1:0]  ofs;
   logic [STRB_W-1:0] strb;
   logic [XLEN-1:0]   wdata_rep;

   assign is_mem    = in_re | in_we;
   assign ofs       = in_alu_out[OFS_W-1:0];
   assign out_valid = (state == HOLD);
   assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready && !flush);
   assign accept    = in_valid && in_ready && !flush;

   always_comb begin
      ale = 1'b0;
      if (ALE_EN && is_mem) begin
         case (in_access_sz)
            ACCESS_SZ_WORD: ale = |in_alu_out[1:0];
            ACCESS_SZ_HALF: ale = in_alu_out[0];
            default:        ale = 1'b0;
         endcase
      end
   end

   // Stores replicate the data across the bus so the strobe alone selects the lanes.
   always_comb begin
      strb      = '0;
      wdata_rep = {(XLEN/32){in_wdata[31:0]}};
      if (in_we) begin
         case (in_access_sz)
            ACCESS_SZ_BYTE: begin
               strb      = STRB_BYTE << ofs;
               wdata_rep = {STRB_W{in_wdata[7:0]}};
            end
            ACCESS_SZ_HALF: begin
               strb      = STRB_HALF << ofs;
               wdata_rep = {(XLEN/16){in_wdata[15:0]}};
            end
            default: strb = STRB_WORD << ofs;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pend_flush <= 1'b0;
         mm_req     <= 1'b0;
         mm_we      <= 1'b0;
         mm_addr    <= '0;
         mm_wdata   <= '0;
         mm_wstrb   <= '0;
         out_result <= '0;
         out_rd_wen <= 1'b0;
         out_ale    <= 1'b0;
      end else if (accept) begin
         out_result <= in_alu_out;
         out_rd_wen <= in_rd_wen & ~ale;
         out_ale    <= ale;
         if (ale) begin
            state <= HOLD;
         end else if (is_mem) begin
            state    <= MEM_REQ;
            mm_req   <= 1'b1;
            mm_we    <= in_we;
            mm_addr  <= in_alu_out;
            mm_wdata <= wdata_rep;
            mm_wstrb <= strb;
         end else if (in_mc) begin
            state <= MC_WAIT;
         end else begin
            state <= HOLD;
         end
      end else begin
         case (state)
            MC_WAIT: begin
               if (flush) begin
                  state <= IDLE;
               end else if (in_mc_valid) begin
                  out_result <= in_mc_out;
                  state      <= HOLD;
               end
            end
            // A request already on the bus cannot be withdrawn; a flush is remembered until the ack.
            MEM_REQ: begin
               if (mm_addr_ok) begin
                  mm_req <= 1'b0;
                  mm_we  <= 1'b0;
                  if (flush || pend_flush) begin
                     pend_flush <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     out_result <= mm_addr;
                     state      <= HOLD;
                  end
               end else if (flush) begin
                  pend_flush <= 1'b1;
               end
            end
            HOLD: begin
               if (flush || out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_mem_ctrl.sv
// Self-checking bench for ex_mem_ctrl: fixed vectors, hand-written handshake
// sequences and randomized transactions against a transaction-level model.
module tb_ex_mem_ctrl;
   localparam logic [2:0] SZ_B = 3'd0;
   localparam logic [2:0] SZ_H = 3'd1;
   localparam logic [2:0] SZ_W = 3'd2;
   localparam int NV = 11;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_re, in_we, in_mc, in_mc_valid, in_rd_wen;
   logic        mm_addr_ok, out_ready;
   logic [2:0]  in_access_sz;
   logic [31:0] in_alu_out, in_wdata, in_mc_out;
   logic        in_ready, mm_req, mm_we, out_valid, out_rd_wen, out_ale;
   logic [31:0] mm_addr, mm_wdata, out_result;
   logic [3:0]  mm_wstrb;
   logic        na_in_ready, na_mm_req, na_mm_we, na_out_valid, na_out_rd_wen, na_out_ale;
   logic [31:0] na_mm_addr, na_mm_wdata, na_out_result;
   logic [3:0]  na_mm_wstrb;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ex_mem_ctrl #(.XLEN(32), .ALE_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_we(in_we), .in_mc(in_mc), .in_access_sz(in_access_sz),
      .in_alu_out(in_alu_out), .in_wdata(in_wdata), .in_mc_out(in_mc_out),
      .in_mc_valid(in_mc_valid), .in_rd_wen(in_rd_wen), .mm_req(mm_req),
      .mm_addr_ok(mm_addr_ok), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
      .mm_wstrb(mm_wstrb), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd_wen(out_rd_wen), .out_ale(out_ale));

   ex_mem_ctrl #(.XLEN(32), .ALE_EN(1'b0)) dut_na (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(na_in_ready),
      .in_re(in_re), .in_we(in_we), .in_mc(in_mc), .in_access_sz(in_access_sz),
      .in_alu_out(in_alu_out), .in_wdata(in_wdata), .in_mc_out(in_mc_out),
      .in_mc_valid(in_mc_valid), .in_rd_wen(in_rd_wen), .mm_req(na_mm_req),
      .mm_addr_ok(mm_addr_ok), .mm_we(na_mm_we), .mm_addr(na_mm_addr), .mm_wdata(na_mm_wdata),
      .mm_wstrb(na_mm_wstrb), .out_valid(na_out_valid), .out_ready(out_ready),
      .out_result(na_out_result), .out_rd_wen(na_out_rd_wen), .out_ale(na_out_ale));

   typedef struct {
      logic        re, we, mc, rdw;
      logic [2:0]  sz;
      logic [31:0] addr, data;
      logic        e_req, e_we, e_valid, e_ale, e_rdw;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t vecs[NV];

   function automatic vec_t mk(input logic re, input logic we, input logic mc, input logic rdw,
                               input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] data,
                               input logic e_req, input logic e_we, input logic e_valid,
                               input logic e_ale, input logic e_rdw, input logic [3:0] e_strb,
                               input logic [31:0] e_wdata);
      vec_t v;
      v.re = re; v.we = we; v.mc = mc; v.rdw = rdw; v.sz = sz; v.addr = addr; v.data = data;
      v.e_req = e_req; v.e_we = e_we; v.e_valid = e_valid; v.e_ale = e_ale; v.e_rdw = e_rdw;
      v.e_strb = e_strb; v.e_wdata = e_wdata;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 1'b0; in_valid = 1'b0; in_re = 1'b0; in_we = 1'b0; in_mc = 1'b0;
      in_access_sz = SZ_B; in_alu_out = '0; in_wdata = '0; in_mc_out = '0;
      in_mc_valid = 1'b0; in_rd_wen = 1'b0; mm_addr_ok = 1'b0; out_ready = 1'b1;
   endtask

   task automatic reset_dut();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic drive_op(input logic re, input logic we, input logic mc, input logic rdw,
                           input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] data);
      in_valid = 1'b1; in_re = re; in_we = we; in_mc = mc; in_rd_wen = rdw;
      in_access_sz = sz; in_alu_out = addr; in_wdata = data;
   endtask

   task automatic random_op(input int n);
      logic re, we, mc, rdw, is_mem, e_ale;
      logic [2:0]  sz;
      logic [31:0] addr, data, mcv, e_wdata, e_res;
      logic [3:0]  e_strb;
      int nb, dly;
      re = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      mc = 1'($urandom_range(0, 1)); rdw = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      addr = $urandom; data = $urandom; mcv = $urandom;
      nb = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
      if ($urandom_range(0, 2) != 0) addr = addr - (addr % nb);
      is_mem  = re | we;
      e_ale   = is_mem && ((addr % nb) != 0);
      e_strb  = we ? 4'(((1 << nb) - 1) << (addr % 4)) : 4'h0;
      e_wdata = (sz == SZ_B) ? (data & 32'hFF) * 32'h01010101 :
                (sz == SZ_H) ? (data & 32'hFFFF) * 32'h00010001 : data;
      e_res   = (!is_mem && mc) ? mcv : addr;

      out_ready = 1'b0;
      drive_op(re, we, mc, rdw, sz, addr, data);
      tick();
      in_valid = 1'b0;
      if (is_mem && !e_ale) begin
         check($sformatf("rnd%0d mm_req", n), mm_req, 1'b1);
         check($sformatf("rnd%0d mm_addr", n), mm_addr, addr);
         check($sformatf("rnd%0d mm_we", n), mm_we, we);
         check($sformatf("rnd%0d mm_wstrb", n), mm_wstrb, e_strb);
         if (we) check($sformatf("rnd%0d mm_wdata", n), mm_wdata, e_wdata);
         dly = $urandom_range(0, 3);
         repeat (dly) tick();
         check($sformatf("rnd%0d mm_req held", n), mm_req, 1'b1);
         mm_addr_ok = 1'b1;
         tick();
         mm_addr_ok = 1'b0;
      end else if (!is_mem && mc) begin
         dly = $urandom_range(0, 3);
         repeat (dly) tick();
         check($sformatf("rnd%0d mc in_ready", n), in_ready, 1'b0);
         in_mc_valid = 1'b1; in_mc_out = mcv;
         tick();
         in_mc_valid = 1'b0;
      end else begin
         check($sformatf("rnd%0d no mm_req", n), mm_req, 1'b0);
      end
      check($sformatf("rnd%0d out_valid", n), out_valid, 1'b1);
      check($sformatf("rnd%0d out_result", n), out_result, e_res);
      check($sformatf("rnd%0d out_ale", n), out_ale, e_ale);
      check($sformatf("rnd%0d out_rd_wen", n), out_rd_wen, rdw & ~e_ale);
      dly = $urandom_range(1, 2);
      repeat (dly) tick();
      check($sformatf("rnd%0d stall result", n), out_result, e_res);
      out_ready = 1'b1;
      tick();
      check($sformatf("rnd%0d retire", n), out_valid, 1'b0);
   endtask

   initial begin
      int req_cycles;
      vecs[0]  = mk(0, 0, 0, 1, SZ_W, 32'h1234, 32'h0,        0, 0, 1, 0, 1, 4'h0, 32'h0);
      vecs[1]  = mk(0, 1, 0, 0, SZ_B, 32'h1003, 32'hAB,       1, 1, 0, 0, 0, 4'h8, 32'hABABABAB);
      vecs[2]  = mk(0, 1, 0, 0, SZ_H, 32'h1002, 32'hBEEF,     1, 1, 0, 0, 0, 4'hC, 32'hBEEFBEEF);
      vecs[3]  = mk(0, 1, 0, 0, SZ_W, 32'h1000, 32'h12345678, 1, 1, 0, 0, 0, 4'hF, 32'h12345678);
      vecs[4]  = mk(1, 0, 0, 1, SZ_W, 32'h1002, 32'h0,        0, 0, 1, 1, 0, 4'h0, 32'h0);
      vecs[5]  = mk(1, 0, 0, 1, SZ_H, 32'h1001, 32'h0,        0, 0, 1, 1, 0, 4'h0, 32'h0);
      vecs[6]  = mk(1, 0, 0, 1, SZ_B, 32'h1003, 32'h0,        1, 0, 0, 0, 1, 4'h0, 32'h0);
      vecs[7]  = mk(1, 1, 0, 1, SZ_B, 32'h1001, 32'h5A,       1, 1, 0, 0, 1, 4'h2, 32'h5A5A5A5A);
      vecs[8]  = mk(0, 0, 1, 1, SZ_W, 32'h0,    32'h0,        0, 0, 0, 0, 1, 4'h0, 32'h0);
      vecs[9]  = mk(0, 1, 0, 0, SZ_H, 32'h1001, 32'h77,       0, 0, 1, 1, 0, 4'h0, 32'h0);
      vecs[10] = mk(1, 0, 1, 1, SZ_W, 32'h1004, 32'h0,        1, 0, 0, 0, 1, 4'h0, 32'h0);

      idle_inputs();
      rst = 1'b1;
      tick();
      check("reset mm_req", mm_req, 1'b0);
      check("reset out_valid", out_valid, 1'b0);
      check("reset flags", {out_ale, out_rd_wen, mm_we}, 3'b000);
      check("reset out_result", out_result, 32'h0);
      check("reset mm_bus", {mm_addr, mm_wdata}, 64'h0);
      check("reset mm_wstrb", mm_wstrb, 4'h0);
      rst = 1'b0;
      #1;
      check("in_ready after reset", in_ready, 1'b1);

      for (int i = 0; i < NV; i++) begin
         reset_dut();
         drive_op(vecs[i].re, vecs[i].we, vecs[i].mc, vecs[i].rdw, vecs[i].sz, vecs[i].addr, vecs[i].data);
         tick();
         in_valid = 1'b0;
         check($sformatf("vec%0d mm_req", i), mm_req, vecs[i].e_req);
         check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_valid);
         check($sformatf("vec%0d out_ale", i), out_ale, vecs[i].e_ale);
         if (vecs[i].e_valid) check($sformatf("vec%0d out_rd_wen", i), out_rd_wen, vecs[i].e_rdw);
         if (vecs[i].e_req) begin
            check($sformatf("vec%0d mm_addr", i), mm_addr, vecs[i].addr);
            check($sformatf("vec%0d mm_we", i), mm_we, vecs[i].e_we);
            check($sformatf("vec%0d mm_wstrb", i), mm_wstrb, vecs[i].e_strb);
            if (vecs[i].e_we) check($sformatf("vec%0d mm_wdata", i), mm_wdata, vecs[i].e_wdata);
         end
      end

      // Back-to-back ALU ops, one result per cycle with no bubble.
      reset_dut();
      drive_op(0, 0, 0, 1, SZ_W, 32'h1234, 32'h0);
      tick();
      check("b2b first result", out_result, 32'h1234);
      check("b2b in_ready", in_ready, 1'b1);
      for (int i = 1; i < 4; i++) begin
         in_alu_out = 32'h1234 + i;
         tick();
         check($sformatf("b2b valid %0d", i), out_valid, 1'b1);
         check($sformatf("b2b result %0d", i), out_result, 32'h1234 + i);
      end
      in_valid = 1'b0;
      tick();
      check("b2b drain", out_valid, 1'b0);

      // Byte store acknowledged in the third request cycle.
      reset_dut();
      drive_op(0, 1, 0, 0, SZ_B, 32'h1003, 32'hAB);
      tick();
      in_valid = 1'b0;
      req_cycles = 0;
      for (int c = 0; c < 3; c++) begin
         if (mm_req) req_cycles++;
         mm_addr_ok = (c == 2);
         tick();
      end
      mm_addr_ok = 1'b0;
      check("store req cycles", req_cycles, 3);
      check("store req dropped", mm_req, 1'b0);
      check("store out_valid", out_valid, 1'b1);
      check("store out_result", out_result, 32'h1003);

      // Misaligned word load with and without detection.
      reset_dut();
      drive_op(1, 0, 0, 1, SZ_W, 32'h1002, 32'h0);
      tick();
      in_valid = 1'b0;
      check("ale0 mm_req issued", na_mm_req, 1'b1);
      check("ale1 no mm_req", mm_req, 1'b0);
      mm_addr_ok = 1'b1;
      tick();
      mm_addr_ok = 1'b0;
      check("ale0 out_valid", na_out_valid, 1'b1);
      check("ale0 out_ale", na_out_ale, 1'b0);
      check("ale0 out_result", na_out_result, 32'h1002);

      // Multi-cycle op waits for its result.
      reset_dut();
      drive_op(0, 0, 1, 1, SZ_W, 32'h0, 32'h0);
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check($sformatf("mc wait in_ready %0d", c), in_ready, 1'b0);
         tick();
      end
      check("mc wait no valid", out_valid, 1'b0);
      in_mc_valid = 1'b1; in_mc_out = 32'hDEAD;
      tick();
      in_mc_valid = 1'b0;
      check("mc out_valid", out_valid, 1'b1);
      check("mc out_result", out_result, 32'hDEAD);

      // Flush during a pending request completes the handshake, then drops the op.
      reset_dut();
      drive_op(0, 1, 0, 1, SZ_W, 32'h2000, 32'h1);
      tick();
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush mm_req held 1", mm_req, 1'b1);
      tick();
      check("flush mm_req held 2", mm_req, 1'b1);
      mm_addr_ok = 1'b1;
      tick();
      mm_addr_ok = 1'b0;
      check("flush mm_req released", mm_req, 1'b0);
      check("flush no out_valid", out_valid, 1'b0);
      check("flush back to idle", in_ready, 1'b1);

      // Stalled HOLD keeps its result, then an async reset clears everything.
      reset_dut();
      out_ready = 1'b0;
      drive_op(0, 0, 0, 1, SZ_W, 32'h55, 32'h0);
      tick();
      in_alu_out = 32'h66;
      for (int c = 0; c < 4; c++) begin
         check($sformatf("stall in_ready %0d", c), in_ready, 1'b0);
         check($sformatf("stall result %0d", c), {out_valid, out_result}, {1'b1, 32'h55});
         tick();
      end
      #2 rst = 1'b1;
      #1;
      check("async rst out_valid", out_valid, 1'b0);
      check("async rst outputs", {out_result, out_rd_wen, out_ale}, 34'h0);
      tick();
      rst = 1'b0;

      // Flush in HOLD and flush alongside an offered op in IDLE.
      reset_dut();
      out_ready = 1'b0;
      drive_op(0, 0, 0, 1, SZ_W, 32'h77, 32'h0);
      tick();
      flush = 1'b1;
      check("flush hold in_ready", in_ready, 1'b0);
      tick();
      check("flush hold cleared", out_valid, 1'b0);
      tick();
      check("flush idle no accept", out_valid, 1'b0);
      flush = 1'b0; in_valid = 1'b0;

      // Reset while a request is outstanding drops mm_req at once.
      reset_dut();
      drive_op(0, 1, 0, 0, SZ_W, 32'h3000, 32'h9);
      tick();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst drops mm_req", mm_req, 1'b0);
      tick();
      rst = 1'b0;

      reset_dut();
      for (int n = 0; n < 40; n++) random_op(n);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/ex_mem_ctrl.md
EX_MEM_CTRL -- requirements
Module: ex_mem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter ALE_EN, default 1, enabling misaligned-access detection (0: out_ale is tied 0).
REQ-003 SHALL have derived constant STRB_W = XLEN/8 and OFS_W = log2(STRB_W).
REQ-004 clk  in  1  sole clock; rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  discard the current/held instruction.
REQ-007 in_valid  in  1  instruction offered by decode.
REQ-008 in_ready  out  1  block accepts the offered instruction this cycle.
REQ-009 in_re / in_we  in  1 each  load / store.
REQ-010 in_mc  in  1  multi-cycle op (mul/div); result comes on in_mc_out.
REQ-011 in_access_sz  in  3  ACCESS_SZ_BYTE/HALF/WORD encodings from defs.v.
REQ-012 in_alu_out, in_wdata, in_mc_out  in  XLEN each  ALU result/address, store data, mul/div result.
REQ-013 in_mc_valid  in  1  in_mc_out valid.
REQ-014 in_rd_wen  in  1  destination-register write enable.
REQ-015 mm_req  out  1  memory request; mm_addr_ok  in  1  request accepted.
REQ-016 mm_we  out  1;  mm_addr  out  XLEN;  mm_wdata  out  XLEN;  mm_wstrb  out  STRB_W.
REQ-017 out_valid  out  1;  out_ready  in  1;  out_result  out  XLEN;  out_rd_wen  out  1;  out_ale  out  1.

Function
REQ-018 SHALL implement states IDLE, MC_WAIT, MEM_REQ, HOLD.
REQ-019 in_ready SHALL be 1 in IDLE, or in HOLD with out_ready=1 and flush=0; 0 otherwise.
REQ-020 Accept (in_valid & in_ready & ~flush) SHALL register all in_* fields in the same edge.
REQ-021 Next state after accept: ale -> HOLD; in_re|in_we -> MEM_REQ; in_mc -> MC_WAIT; else HOLD.
REQ-022 Non-memory, non-mc op SHALL give out_valid exactly 1 cycle after accept (latency 1).
REQ-023 out_valid SHALL equal (state==HOLD); HOLD SHALL keep all outputs stable until out_ready.
REQ-024 HOLD with out_ready and no new accept SHALL go IDLE; with accept SHALL follow REQ-021 (back-to-back, no bubble).
REQ-025 MC_WAIT: on in_mc_valid, latch in_mc_out into out_result and go HOLD; wait indefinitely otherwise.
REQ-026 MEM_REQ: mm_req=1 with mm_addr/mm_we/mm_wdata/mm_wstrb stable; on mm_addr_ok go HOLD, out_result = address.
REQ-027 mm_req SHALL be 0 in all states other than MEM_REQ.
REQ-028 ale (ALE_EN=1, re|we): WORD -> addr[1:0]!=0; HALF -> addr[0]; BYTE -> 0; non-memory -> 0.
REQ-029 Misaligned op SHALL never assert mm_req; out_ale=1 and out_rd_wen=0 in HOLD.
REQ-030 mm_wdata SHALL replicate store data: BYTE -> data[7:0] in every byte; HALF -> data[15:0] in every halfword; WORD -> data[31:0] in every word.
REQ-031 mm_wstrb: BYTE -> 1 at addr[OFS_W-1:0]; HALF -> 2'b11 at that offset; WORD -> 4'hF at that offset; loads -> all 0.
REQ-032 flush in IDLE, MC_WAIT or HOLD SHALL go IDLE next cycle, out_valid 0, no accept that cycle.
REQ-033 flush in MEM_REQ SHALL keep mm_req asserted until mm_addr_ok (no withdrawal), then go IDLE with no out_valid; a pending-flush flag SHALL record it.
REQ-034 in_valid with in_re & in_we both 1 SHALL be treated as store.

Reset
REQ-035 rst SHALL asynchronously force IDLE, clear pending-flush, and drive mm_req, out_valid, out_ale, out_rd_wen, mm_we to 0 and out_result, mm_addr, mm_wdata, mm_wstrb to 0.
REQ-036 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-037 rst mid-MEM_REQ SHALL drop mm_req immediately; no result is produced.

Verification
REQ-038 ALU op, in_alu_out=32'h1234, out_ready=1 -> out_valid next cycle, out_result=32'h1234, in_ready stays 1, back-to-back ops each 1 cycle.
REQ-039 Byte store addr=32'h1003, data=32'hAB, mm_addr_ok after 3 cycles -> mm_req 3 cycles, mm_wstrb=4'b1000, mm_wdata=32'hABABABAB, then out_valid.
REQ-040 Word load addr=32'h1002 -> no mm_req, out_valid next cycle with out_ale=1, out_rd_wen=0; same with ALE_EN=0 -> mm_req issued, out_ale=0.
REQ-041 mul op, in_mc_valid after 5 cycles with in_mc_out=32'hDEAD -> in_ready 0 for those cycles, out_result=32'hDEAD then out_valid.
REQ-042 Flush in MEM_REQ with mm_addr_ok delayed 2 cycles -> mm_req held until ack, then IDLE, out_valid never asserted.
REQ-043 out_ready=0 for 4 cycles in HOLD -> outputs stable, in_ready 0; rst mid-HOLD -> all outputs 0 asynchronously.
